// File: rtl/int_perceptron_trainer.sv
// int_perceptron_trainer: sequential perceptron-rule trainer for the 2-input
// Q3.12 sign-magnitude perceptron. Iterates a 4-sample truth table until an
// epoch passes with zero errors or MAX_EPOCHS is reached, then holds weights.
// Optional macro INT_TRAINER_INIT_EN adds w0_init/w1_init/w2_init ports that
// seed the weights at LOAD instead of clearing them.
module int_perceptron_trainer #(
  parameter int TAM        = 16,
  parameter int MAX_EPOCHS = 16,
  parameter int EPOCH_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*TAM-1:0]   x1_in,
  input  logic [4*TAM-1:0]   x2_in,
  input  logic [4*TAM-1:0]   d_in,
  input  logic [TAM-1:0]     eta,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [TAM-1:0]     w0,
  output logic [TAM-1:0]     w1,
  output logic [TAM-1:0]     w2,
  output logic [EPOCH_W-1:0] epoch_cnt
`ifdef INT_TRAINER_INIT_EN
  ,
  input  logic [TAM-1:0]     w0_init,
  input  logic [TAM-1:0]     w1_init,
  input  logic [TAM-1:0]     w2_init
`endif
);

  localparam int FRAC = 12;
  localparam int MW   = TAM - 1;        // magnitude width
  localparam int PW   = 2 * MW;         // raw magnitude product width
  localparam int NW   = TAM + 6;        // internal two's complement width, no overflow possible
  localparam logic [NW-1:0]      MAG_MAX   = {{(NW-MW){1'b0}}, {MW{1'b1}}};
  localparam logic [TAM-1:0]     ONE       = {{(TAM-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [TAM-1:0]     NEG_ZERO  = {1'b1, {MW{1'b0}}};
  localparam logic [EPOCH_W-1:0] EPOCH_MAX = EPOCH_W'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_EVAL   = 3'd2,
    S_UPDATE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Sign-magnitude to two's complement; negative zero collapses to zero.
  function automatic logic signed [NW-1:0] sm_to_tc(input logic [TAM-1:0] v);
    logic signed [NW-1:0] mag;
    mag = {{(NW-MW){1'b0}}, v[MW-1:0]};
    if (v[TAM-1]) return -mag;
    else return mag;
  endfunction

  // Q3.12 product: magnitude multiply, truncate toward zero, then apply sign.
  function automatic logic signed [NW-1:0] q_mul(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
    logic [PW-1:0]        prod;
    logic signed [NW-1:0] mag;
    prod = {{MW{1'b0}}, a[MW-1:0]} * {{MW{1'b0}}, b[MW-1:0]};
    mag  = {{(NW-(PW-FRAC)){1'b0}}, prod[PW-1:FRAC]};
    if (a[TAM-1] ^ b[TAM-1]) return -mag;
    else return mag;
  endfunction

  // Two's complement back to sign-magnitude with symmetric saturation; never yields -0.
  function automatic logic [TAM-1:0] tc_to_sm_sat(input logic signed [NW-1:0] v);
    logic [NW-1:0] mag;
    if (v[NW-1]) mag = -v;
    else mag = v;
    if (mag > MAG_MAX) mag = MAG_MAX;
    else mag = mag;
    return {v[NW-1], mag[MW-1:0]};
  endfunction

  // Replace negative zero with positive zero.
  function automatic logic [TAM-1:0] sm_norm(input logic [TAM-1:0] v);
    if (v == NEG_ZERO) return {TAM{1'b0}};
    else return v;
  endfunction

  // Select sample k from a packed 4-word vector.
  function automatic logic [TAM-1:0] pick(input logic [4*TAM-1:0] vec, input logic [1:0] k);
    case (k)
      2'd0:    return vec[TAM-1:0];
      2'd1:    return vec[2*TAM-1:TAM];
      2'd2:    return vec[3*TAM-1:2*TAM];
      2'd3:    return vec[4*TAM-1:3*TAM];
      default: return {TAM{1'b0}};
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [4*TAM-1:0]     x1_q, x1_d, x2_q, x2_d, d_q, d_d;
  logic [TAM-1:0]       eta_q, eta_d;
  logic [TAM-1:0]       w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic [1:0]           k_q, k_d;
  logic                 err_flag_q, err_flag_d;
  logic                 y_q, y_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 done_arm_q, done_arm_d;
  logic                 conv_q, conv_d;

  logic [TAM-1:0]       x1_k, x2_k, d_k, eta_pos;
  logic signed [NW-1:0] net, delta0, delta1, delta2;
  logic                 err_pos, err_neg;
  logic [TAM-1:0]       init0, init1, init2;

`ifdef INT_TRAINER_INIT_EN
  assign init0 = sm_norm(w0_init);
  assign init1 = sm_norm(w1_init);
  assign init2 = sm_norm(w2_init);
`else
  assign init0 = {TAM{1'b0}};
  assign init1 = {TAM{1'b0}};
  assign init2 = {TAM{1'b0}};
`endif

  // Next-state logic, datapath and output decode for the training FSM.
  always_comb begin
    state_d    = state_q;
    x1_d       = x1_q;
    x2_d       = x2_q;
    d_d        = d_q;
    eta_d      = eta_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    epoch_d    = epoch_q;
    k_d        = k_q;
    err_flag_d = err_flag_q;
    y_d        = y_q;
    busy_d     = busy_q;
    conv_d     = conv_q;
    done_arm_d = 1'b0;
    done_d     = done_arm_q;

    x1_k    = pick(x1_q, k_q);
    x2_k    = pick(x2_q, k_q);
    d_k     = pick(d_q, k_q);
    eta_pos = {1'b0, eta_q[MW-1:0]};
    net     = sm_to_tc(w0_q) + q_mul(w1_q, x1_k) + q_mul(w2_q, x2_k);
    delta0  = sm_to_tc(eta_pos);
    delta1  = q_mul(eta_pos, x1_k);
    delta2  = q_mul(eta_pos, x2_k);
    err_pos = (d_k == ONE) & ~y_q;
    err_neg = (d_k != ONE) & y_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        x1_d       = x1_in;
        x2_d       = x2_in;
        d_d        = d_in;
        eta_d      = eta;
        w0_d       = init0;
        w1_d       = init1;
        w2_d       = init2;
        epoch_d    = {EPOCH_W{1'b0}};
        err_flag_d = 1'b0;
        k_d        = 2'd0;
        conv_d     = 1'b0;
        busy_d     = 1'b1;
        state_d    = S_EVAL;
      end
      S_EVAL: begin
        y_d     = ~net[NW-1];
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (err_pos) begin
          w0_d       = tc_to_sm_sat(sm_to_tc(w0_q) + delta0);
          w1_d       = tc_to_sm_sat(sm_to_tc(w1_q) + delta1);
          w2_d       = tc_to_sm_sat(sm_to_tc(w2_q) + delta2);
          err_flag_d = 1'b1;
        end else if (err_neg) begin
          w0_d       = tc_to_sm_sat(sm_to_tc(w0_q) - delta0);
          w1_d       = tc_to_sm_sat(sm_to_tc(w1_q) - delta1);
          w2_d       = tc_to_sm_sat(sm_to_tc(w2_q) - delta2);
          err_flag_d = 1'b1;
        end else begin
          err_flag_d = err_flag_q;
        end
        if (k_q == 2'd3) begin
          state_d = S_CHECK;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_EVAL;
        end
      end
      S_CHECK: begin
        if (epoch_q == EPOCH_MAX) epoch_d = epoch_q;
        else epoch_d = epoch_q + {{(EPOCH_W-1){1'b0}}, 1'b1};
        if (!err_flag_q) begin
          conv_d     = 1'b1;
          busy_d     = 1'b0;
          done_arm_d = 1'b1;
          state_d    = S_DONE;
        end else if (epoch_q + {{(EPOCH_W-1){1'b0}}, 1'b1} == EPOCH_MAX) begin
          conv_d     = 1'b0;
          busy_d     = 1'b0;
          done_arm_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          err_flag_d = 1'b0;
          k_d        = 2'd0;
          state_d    = S_EVAL;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x1_q       <= {(4*TAM){1'b0}};
      x2_q       <= {(4*TAM){1'b0}};
      d_q        <= {(4*TAM){1'b0}};
      eta_q      <= {TAM{1'b0}};
      w0_q       <= {TAM{1'b0}};
      w1_q       <= {TAM{1'b0}};
      w2_q       <= {TAM{1'b0}};
      epoch_q    <= {EPOCH_W{1'b0}};
      k_q        <= 2'd0;
      err_flag_q <= 1'b0;
      y_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_arm_q <= 1'b0;
      conv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      d_q        <= d_d;
      eta_q      <= eta_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      epoch_q    <= epoch_d;
      k_q        <= k_d;
      err_flag_q <= err_flag_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_arm_q <= done_arm_d;
      conv_q     <= conv_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign w0        = w0_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign epoch_cnt = epoch_q;

endmodule

// File: tb/tb_int_perceptron_trainer.sv
// Self-checking bench for int_perceptron_trainer: directed OR/XOR/saturation,
// start-while-busy, async reset, and randomized runs against a behavioural
// model. With INT_TRAINER_INIT_EN it also exercises the weight-seed ports.
module tb_int_perceptron_trainer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] x1_in = 64'd0, x2_in = 64'd0, d_in = 64'd0;
  logic [15:0] eta = 16'd0;
  logic        busy, done, converged;
  logic [15:0] w0, w1, w2;
  logic [4:0]  epoch_cnt;
  logic [15:0] iw0 = 16'd0, iw1 = 16'd0, iw2 = 16'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_perceptron_trainer #(.TAM(16), .MAX_EPOCHS(16), .EPOCH_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x1_in(x1_in), .x2_in(x2_in), .d_in(d_in), .eta(eta),
    .busy(busy), .done(done), .converged(converged),
    .w0(w0), .w1(w1), .w2(w2), .epoch_cnt(epoch_cnt)
`ifdef INT_TRAINER_INIT_EN
    , .w0_init(iw0), .w1_init(iw1), .w2_init(iw2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model (plain integer arithmetic) --------------
  function automatic int sm2i(input logic [15:0] v);
    int m;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic int qmul_m(input int a, input int b);
    int m;
    m = ((a < 0 ? -a : a) * (b < 0 ? -b : b)) / 4096;
    return ((a < 0) != (b < 0)) ? -m : m;
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic logic [15:0] i2sm(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return {(v < 0) ? 1'b1 : 1'b0, m[14:0]};
  endfunction

  task automatic ref_model(output logic [15:0] ew0, output logic [15:0] ew1, output logic [15:0] ew2,
                           output int eep, output bit econv);
    int w[3];
    int etam, xa, xb, net, e;
    bit errs;
    w[0] = sm2i(iw0); w[1] = sm2i(iw1); w[2] = sm2i(iw2);
    etam = int'(eta[14:0]);
    econv = 1'b0;
    eep = 0;
    for (int ep = 1; ep <= 16; ep++) begin
      errs = 1'b0;
      for (int k = 0; k < 4; k++) begin
        xa  = sm2i(x1_in[16*k +: 16]);
        xb  = sm2i(x2_in[16*k +: 16]);
        net = w[0] + qmul_m(w[1], xa) + qmul_m(w[2], xb);
        e   = ((d_in[16*k +: 16] == 16'h1000) ? 1 : 0) - ((net >= 0) ? 1 : 0);
        if (e != 0) begin
          w[0] = clamp(w[0] + e * etam);
          w[1] = clamp(w[1] + e * qmul_m(etam, xa));
          w[2] = clamp(w[2] + e * qmul_m(etam, xb));
          errs = 1'b1;
        end
      end
      eep = ep;
      if (!errs) begin
        econv = 1'b1;
        break;
      end
    end
    ew0 = i2sm(w[0]); ew1 = i2sm(w[1]); ew2 = i2sm(w[2]);
  endtask

  // Start a run; pulse start again after edge pulse_at (0 = never); scramble inputs after LOAD.
  task automatic do_run(input int pulse_at, output int lat, output bit nz_seen);
    lat = -1;
    nz_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        x1_in = {$urandom, $urandom};
        x2_in = {$urandom, $urandom};
        d_in  = {$urandom, $urandom};
        eta   = 16'($urandom);
      end
      start = (e == pulse_at) ? 1'b1 : 1'b0;
      if (w0 == 16'h8000 || w1 == 16'h8000 || w2 == 16'h8000) nz_seen = 1'b1;
      if (done) begin
        lat = e;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Full run checked against the model; returns observed latency.
  task automatic train_check(input string tag, input int pulse_at, output int lat);
    logic [15:0] ew0, ew1, ew2;
    int eep;
    bit econv, nz;
    ref_model(ew0, ew1, ew2, eep, econv);
    do_run(pulse_at, lat, nz);
    chk({tag, "_latency"}, 32'(lat), 32'(2 + 9 * eep));
    chk({tag, "_conv"}, {31'd0, converged}, {31'd0, econv});
    chk({tag, "_epochs"}, {27'd0, epoch_cnt}, 32'(eep));
    chk({tag, "_w0"}, {16'd0, w0}, {16'd0, ew0});
    chk({tag, "_w1"}, {16'd0, w1}, {16'd0, ew1});
    chk({tag, "_w2"}, {16'd0, w2}, {16'd0, ew2});
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_no_neg_zero"}, {31'd0, nz}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_w0_hold"}, {16'd0, w0}, {16'd0, ew0});
  endtask

  task automatic set_or();
    x1_in = {16'h1000, 16'h0000, 16'h1000, 16'h0000};
    x2_in = {16'h1000, 16'h1000, 16'h0000, 16'h0000};
    d_in  = {16'h1000, 16'h1000, 16'h1000, 16'h0000};
    eta   = 16'h0800;
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] r;
    case ($urandom_range(0, 5))
      0: r = 16'h7FFF;
      1: r = 16'hFFFF;
      2: r = 16'h8000;
      3: r = 16'h1000;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    int lat;
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_conv", {31'd0, converged}, 32'd0);
    chk("rst_w", {w0, w1}, 32'd0);
    chk("rst_w2_epoch", {11'd0, epoch_cnt, w2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // OR training with the documented result
    set_or();
    train_check("or", 0, lat);
    chk("or_lat38", 32'(lat), 32'd38);
    chk("or_const_w", {w0, w1}, {16'h8800, 16'h0800});
    chk("or_const_w2_ep", {11'd0, epoch_cnt, w2}, {11'd0, 5'd4, 16'h0800});
    chk("or_const_conv", {31'd0, converged}, 32'd1);

    // XOR: never converges, stops at the epoch limit
    set_or();
    d_in = {16'h0000, 16'h1000, 16'h1000, 16'h0000};
    train_check("xor", 0, lat);
    chk("xor_const", {26'd0, converged, epoch_cnt}, {26'd0, 1'b0, 5'd16});

    // Saturation-prone inputs
    x1_in = {4{16'h7FFF}};
    x2_in = {4{16'h7FFF}};
    d_in  = {4{16'h1000}};
    eta   = 16'h7FFF;
    train_check("sat", 0, lat);
    x1_in = {16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h7FFF};
    x2_in = {16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF};
    d_in  = {16'h0000, 16'h1000, 16'h0000, 16'h1000};
    eta   = 16'hFFFF;
    train_check("sat2", 0, lat);

    // start pulsed during EVAL of epoch 2 is ignored
    set_or();
    train_check("or_pulse", 10, lat);
    chk("or_pulse_lat38", 32'(lat), 32'd38);

    // Async reset in the middle of an UPDATE cycle
    set_or();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_w0", {16'd0, w0}, {16'd0, 16'h8800});
    rst_n = 1'b0;
    #1;
    chk("arst_busy_done_conv", {29'd0, busy, done, converged}, 32'd0);
    chk("arst_w", {w0, w1}, 32'd0);
    chk("arst_w2_epoch", {11'd0, epoch_cnt, w2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_or();
    train_check("or_after_rst", 0, lat);
    chk("or_after_rst_w0", {16'd0, w0}, {16'd0, 16'h8800});

    // Randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      x1_in = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      x2_in = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
      for (int k = 0; k < 4; k++) d_in[16*k +: 16] = ($urandom_range(0, 1) == 1) ? 16'h1000 : 16'h0000;
      eta = rnd_word();
      train_check($sformatf("rnd%0d", r), 0, lat);
    end

`ifdef INT_TRAINER_INIT_EN
    // Seeded weights already solve OR
    iw0 = 16'h8800; iw1 = 16'h0800; iw2 = 16'h0800;
    set_or();
    train_check("init_or", 0, lat);
    chk("init_or_const", {10'd0, converged, epoch_cnt, w0}, {10'd0, 1'b1, 5'd1, 16'h8800});
    iw0 = 16'h8000; iw1 = 16'h8000; iw2 = 16'h0000;
    set_or();
    train_check("init_negzero", 0, lat);
    iw0 = 16'h0000; iw1 = 16'h0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
